// File: rtl/gated_deser.sv
`default_nettype none
// ============================================================================
// Module      : gated_deser
// Description : Serial-to-parallel capture stage fed by the gated serial bit
//               of the mux2_and merge cell. Bits are sampled on qualified
//               edges (bit_valid_i) and packed LSB first into WIDTH-bit words.
//               Completed words are held in a valid/ready output register.
//               A word that completes while the output is still occupied
//               and not being consumed is dropped, and a sticky overrun
//               flag is raised.
// Ports       : clk_i       - clock, rising edge
//               rst_ni      - asynchronous active-low reset
//               bit_i       - serial data bit (upstream y_o)
//               bit_valid_i - sample bit_i on this edge
//               clear_i     - synchronous restart of all state
//               data_o      - last completed word
//               valid_o     - data_o holds an unconsumed word
//               ready_i     - consumer takes data_o when valid_o=1
//               bit_cnt_o   - bits collected for the word in progress
//               overrun_o   - sticky: a completed word was dropped
//               VDD/GND     - supply pins, present only under PWR_PINS
// Revision    : 1.0 - initial release
// ============================================================================
module gated_deser #(
    parameter int WIDTH = 8
) (
`ifdef PWR_PINS
    input  logic                     VDD,
    input  logic                     GND,
`endif
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     bit_i,
    input  logic                     bit_valid_i,
    input  logic                     clear_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(WIDTH)-1:0] bit_cnt_o,
    output logic                     overrun_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_data;
    logic               r_overrun;

    logic [WIDTH-1:0]   w_sr_next;
    logic               w_done;

    // New bits enter at the MSB, so after WIDTH shifts the first bit is at bit 0.
    assign w_sr_next = {bit_i, r_sr[WIDTH-1:1]};
    assign w_done    = bit_valid_i && (r_cnt == c_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_EMPTY;
            r_sr      <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else if (clear_i) begin
            r_state   <= ST_EMPTY;
            r_sr      <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            // Shifting continues straight into the next word; the output
            // state never stalls collection.
            if (bit_valid_i) begin
                r_sr  <= w_sr_next;
                r_cnt <= w_done ? '0 : r_cnt + CNT_W'(1);
            end

            case (r_state)
                ST_EMPTY: begin
                    if (w_done) begin
                        r_data  <= w_sr_next;
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_done && ready_i) begin
                        // Old word leaves as the new one arrives: no loss.
                        r_data <= w_sr_next;
                    end else if (w_done) begin
                        // Output still occupied: drop the new word.
                        r_overrun <= 1'b1;
                    end else if (ready_i) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign data_o    = r_data;
    assign valid_o   = (r_state == ST_FULL);
    assign bit_cnt_o = r_cnt;
    assign overrun_o = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_gated_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_gated_deser
// Description : Self-checking bench for gated_deser (WIDTH=8). Directed
//               sequences plus randomized traffic, compared each edge with a
//               word-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gated_deser;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH);

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              bit_i;
    logic              bit_valid_i;
    logic              clear_i;
    logic              ready_i;
    logic [WIDTH-1:0]  data_o;
    logic              valid_o;
    logic [CNT_W-1:0]  bit_cnt_o;
    logic              overrun_o;

    gated_deser #(.WIDTH(WIDTH)) dut (
`ifdef PWR_PINS
        .VDD         (1'b1),
        .GND         (1'b0),
`endif
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bit_i       (bit_i),
        .bit_valid_i (bit_valid_i),
        .clear_i     (clear_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .bit_cnt_o   (bit_cnt_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: words are accumulated with plain arithmetic
    // (bit k of the word = k-th accepted bit) and the output is a one-slot
    // buffer that may be emptied and refilled on the same edge.
    int          m_cnt;
    int unsigned m_acc;
    int unsigned m_data;
    bit          m_valid;
    bit          m_ovr;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_acc = 0; m_data = 0; m_valid = 0; m_ovr = 0;
    endtask

    task automatic model_edge(input bit bv, input bit b, input bit rdy, input bit clr);
        bit          done;
        int unsigned word;
        if (clr) begin
            model_reset();
            return;
        end
        done = 0;
        word = 0;
        if (bv) begin
            m_acc = m_acc + (int'(b) << m_cnt);
            m_cnt = m_cnt + 1;
            if (m_cnt == WIDTH) begin
                done  = 1;
                word  = m_acc;
                m_acc = 0;
                m_cnt = 0;
            end
        end
        if (m_valid && rdy) m_valid = 0;     // transfer to consumer
        if (done) begin
            if (m_valid) m_ovr = 1;          // slot still occupied: drop
            else begin
                m_data  = word;
                m_valid = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"},  32'(data_o),    m_data);
        chk({tag, ".valid"}, 32'(valid_o),   32'(m_valid));
        chk({tag, ".cnt"},   32'(bit_cnt_o), 32'(m_cnt));
        chk({tag, ".ovr"},   32'(overrun_o), 32'(m_ovr));
    endtask

    task automatic step(input string tag, input bit bv, input bit b, input bit rdy, input bit clr);
        bit_valid_i = bv; bit_i = b; ready_i = rdy; clear_i = clr;
        @(posedge clk_i);
        model_edge(bv, b, rdy, clr);
        #1;
        check_all(tag);
    endtask

    // Sends one word LSB first; ready_i asserted only on the final edge if asked.
    task automatic send_word(input string tag, input logic [WIDTH-1:0] w, input bit rdy_last);
        for (int i = 0; i < WIDTH; i++)
            step(tag, 1'b1, w[i], rdy_last && (i == WIDTH - 1), 1'b0);
    endtask

    initial begin
        rst_ni = 1'b0; bit_i = 1'b0; bit_valid_i = 1'b0; clear_i = 1'b0; ready_i = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // 1,0,1,0,0,1,0,1 LSB first -> 0xA5
        send_word("a5", 8'hA5, 1'b0);
        chk("a5.const_data", 32'(data_o), 32'hA5);
        chk("a5.const_valid", 32'(valid_o), 32'd1);

        step("consume", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("consume.const_valid", 32'(valid_o), 32'd0);
        chk("consume.const_data", 32'(data_o), 32'hA5);

        send_word("3c", 8'h3C, 1'b0);
        send_word("c3", 8'hC3, 1'b1);
        chk("c3.const_data", 32'(data_o), 32'hC3);
        chk("c3.const_ovr", 32'(overrun_o), 32'd0);

        step("drain", 1'b0, 1'b0, 1'b1, 1'b0);
        send_word("11", 8'h11, 1'b0);
        send_word("22", 8'h22, 1'b0);
        chk("ovr.const_data", 32'(data_o), 32'h11);
        chk("ovr.const_flag", 32'(overrun_o), 32'd1);
        step("clear", 1'b1, 1'b1, 1'b1, 1'b1);
        chk("clear.const_valid", 32'(valid_o), 32'd0);

        for (int i = 0; i < 5; i++) step("part", 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b0;
        model_reset();
        #1;
        chk("midrst.const_cnt", 32'(bit_cnt_o), 32'd0);
        check_all("midrst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        send_word("ff", 8'hFF, 1'b0);
        chk("ff.const_data", 32'(data_o), 32'hFF);

        step("drain2", 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step("idle", 1'b0, 1'(i & 1), 1'b0, 1'b0);
        chk("idle.const_cnt", 32'(bit_cnt_o), 32'd0);
        chk("idle.const_valid", 32'(valid_o), 32'd0);

        for (int i = 0; i < 600; i++) begin
            step("rand",
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 79) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
